// File: rtl/regfile_wb_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_scheduler_if
//  Description : Bundles the write-back requester bus, the register-file
//                write port and the issue-hazard query of the scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_scheduler_if #(
  parameter int N_REQ = 3,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*AW-1:0] req_rd;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_grant;
  logic                RegWrite;
  logic [AW-1:0]       Rd;
  logic [DW-1:0]       Write_data;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic [AW-1:0]       issue_rs1;
  logic [AW-1:0]       issue_rs2;
  logic                issue_uses_rs2;
  logic                stall;
  logic [31:0]         pending;

  // Execute units and issue stage side
  modport master (
    output req_valid, req_rd, req_data,
    output issue_valid, issue_rd, issue_rs1, issue_rs2, issue_uses_rs2,
    input  req_grant, RegWrite, Rd, Write_data, stall, pending
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_rd, req_data,
    input  issue_valid, issue_rd, issue_rs1, issue_rs2, issue_uses_rs2,
    output req_grant, RegWrite, Rd, Write_data, stall, pending
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_scheduler
//  Description : Round-robin arbiter for the single register-file write port
//                plus a pending-write scoreboard that stalls issue on RAW/WAW.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
  parameter int N_REQ = 3,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  regfile_wb_scheduler_if.slave bus
);
  localparam int c_PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_NREG = 32;

  logic [c_PW-1:0]   r_ptr;
  logic              r_reg_write;
  logic [AW-1:0]     r_rd;
  logic [DW-1:0]     r_wdata;
  logic [c_NREG-1:0] r_pending;

  logic [N_REQ-1:0]  w_grant;
  logic              w_found;
  logic [c_PW-1:0]   w_gidx;
  logic [c_PW-1:0]   w_ptr_next;
  logic [AW-1:0]     w_grd;
  logic [DW-1:0]     w_gdata;
  logic              w_write;
  logic              w_issue_ok;
  logic              w_stall;
  logic [c_NREG-1:0] w_set_vec;
  logic [c_NREG-1:0] w_clr_vec;

  // Round-robin search from r_ptr; no grant at all while reset is held
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(r_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_found && !rst && bus.req_valid[idx]) begin
        w_found      = 1'b1;
        w_gidx       = c_PW'(idx);
        w_grant[idx] = 1'b1;
      end
    end
  end

  // Pointer moves to one past the winner; x0 writes still consume a turn
  always_comb begin
    w_ptr_next = r_ptr;
    if (w_found) begin
      w_ptr_next = (int'(w_gidx) == N_REQ - 1) ? '0 : w_gidx + c_PW'(1);
    end
  end

  assign w_grd   = bus.req_rd[w_gidx*AW +: AW];
  assign w_gdata = bus.req_data[w_gidx*DW +: DW];
  // A grant to x0 is swallowed: no port write and no scoreboard effect
  assign w_write = w_found && (w_grd != '0);

  // Hazard detection against in-flight destinations; x0 never conflicts
  always_comb begin
    w_stall = 1'b0;
    if (bus.issue_valid) begin
      if ((bus.issue_rs1 != '0) && r_pending[bus.issue_rs1]) w_stall = 1'b1;
      if (bus.issue_uses_rs2 && (bus.issue_rs2 != '0) && r_pending[bus.issue_rs2]) w_stall = 1'b1;
      if ((bus.issue_rd != '0) && r_pending[bus.issue_rd]) w_stall = 1'b1;
    end
  end

  assign w_issue_ok = bus.issue_valid && !w_stall && (bus.issue_rd != '0);
  assign w_set_vec  = w_issue_ok ? (c_NREG'(1) << bus.issue_rd) : '0;
  assign w_clr_vec  = w_write    ? (c_NREG'(1) << w_grd)        : '0;

  // Arbiter pointer register
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else     r_ptr <= w_ptr_next;
  end

  // Register-file write port; address/data hold between writes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_wdata     <= '0;
    end else begin
      r_reg_write <= w_write;
      if (w_write) begin
        r_rd    <= w_grd;
        r_wdata <= w_gdata;
      end
    end
  end

  // Scoreboard: clear on write-back, set on issue, set wins; bit 0 tied low
  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= ((r_pending & ~w_clr_vec) | w_set_vec) & ~c_NREG'(1);
  end

  assign bus.req_grant  = w_grant;
  assign bus.RegWrite   = r_reg_write;
  assign bus.Rd         = r_rd;
  assign bus.Write_data = r_wdata;
  assign bus.stall      = w_stall;
  assign bus.pending    = r_pending;
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_scheduler
//  Description : Directed self-checking bench for regfile_wb_scheduler with a
//                write-back scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;
  localparam int N_REQ = 3;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_scheduler_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) bus ();

  regfile_wb_scheduler #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_total = 0;
  int  n_pass  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    bus.req_valid[i]         = v;
    bus.req_rd[i*AW +: AW]   = rd;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic issue(input logic v, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic u);
    bus.issue_valid    = v;
    bus.issue_rd       = rd;
    bus.issue_rs1      = rs1;
    bus.issue_rs2      = rs2;
    bus.issue_uses_rs2 = u;
  endtask

  task automatic push(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    wb_t e;
    e.rd   = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Write-back monitor: every RegWrite pulse must match the oldest expected write
  initial begin
    wb_t e;
    forever begin
      @(posedge clk);
      #3;
      if (bus.RegWrite === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wb_rd", 64'(bus.Rd), 64'(e.rd));
          chk("wb_data", 64'(bus.Write_data), 64'(e.data));
        end
      end
    end
  end

  // Directed sequence
  initial begin
    // Reset with every requester valid
    rst = 1'b1;
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_req(0, 1'b1, 5'd1, 32'hA);
    set_req(1, 1'b1, 5'd2, 32'hB);
    set_req(2, 1'b1, 5'd3, 32'hC);
    #1;
    chk("reset_grant", 64'(bus.req_grant), 64'd0);
    step();
    chk("reset_regwrite", 64'(bus.RegWrite), 64'd0);
    chk("reset_rd", 64'(bus.Rd), 64'd0);
    chk("reset_wdata", 64'(bus.Write_data), 64'd0);
    chk("reset_pending", 64'(bus.pending), 64'd0);
    rst = 1'b0;
    settle();
    chk("rr_grant0", 64'(bus.req_grant), 64'b001);
    push(5'd1, 32'hA);

    // Round-robin: ALU re-presents, others hold until granted
    step();
    chk("rr_regwrite0", 64'(bus.RegWrite), 64'd1);
    set_req(0, 1'b1, 5'd4, 32'hD);
    settle();
    chk("rr_grant1", 64'(bus.req_grant), 64'b010);
    push(5'd2, 32'hB);
    step();
    chk("rr_regwrite1", 64'(bus.RegWrite), 64'd1);
    set_req(1, 1'b0, 5'd0, 32'h0);
    settle();
    chk("rr_grant2", 64'(bus.req_grant), 64'b100);
    push(5'd3, 32'hC);
    step();
    chk("rr_regwrite2", 64'(bus.RegWrite), 64'd1);
    set_req(2, 1'b0, 5'd0, 32'h0);
    settle();
    chk("rr_grant_wrap", 64'(bus.req_grant), 64'b001);
    push(5'd4, 32'hD);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    settle();
    chk("idle_grant", 64'(bus.req_grant), 64'd0);
    step();
    chk("idle_regwrite", 64'(bus.RegWrite), 64'd0);
    chk("idle_rd_hold", 64'(bus.Rd), 64'd4);

    // RAW hazard on x5
    issue(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    settle();
    chk("raw_first_stall", 64'(bus.stall), 64'd0);
    step();
    chk("raw_pending_set", 64'(bus.pending), 64'h20);
    issue(1'b1, 5'd0, 5'd5, 5'd0, 1'b0);
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    settle();
    chk("raw_stall", 64'(bus.stall), 64'd1);
    chk("raw_grant_lsu", 64'(bus.req_grant), 64'b010);
    push(5'd5, 32'hDEADBEEF);
    step();
    chk("raw_pending_clr", 64'(bus.pending), 64'd0);
    chk("raw_regwrite", 64'(bus.RegWrite), 64'd1);
    chk("raw_stall_drop", 64'(bus.stall), 64'd0);
    set_req(1, 1'b0, 5'd0, 32'h0);
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // WAW on x7, x0 write, x0 sources
    issue(1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
    settle();
    chk("waw_first_stall", 64'(bus.stall), 64'd0);
    step();
    chk("waw_pending", 64'(bus.pending), 64'h80);
    settle();
    chk("waw_stall", 64'(bus.stall), 64'd1);
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_req(2, 1'b1, 5'd0, 32'h1234);
    settle();
    chk("x0_grant", 64'(bus.req_grant), 64'b100);
    step();
    chk("x0_regwrite", 64'(bus.RegWrite), 64'd0);
    chk("x0_rd_hold", 64'(bus.Rd), 64'd5);
    chk("x0_wdata_hold", 64'(bus.Write_data), 64'hDEADBEEF);
    chk("x0_pending", 64'(bus.pending), 64'h80);
    set_req(2, 1'b0, 5'd0, 32'h0);
    issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    settle();
    chk("rs1_x0_stall", 64'(bus.stall), 64'd0);
    issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b0);
    settle();
    chk("rs2_unused_stall", 64'(bus.stall), 64'd0);
    issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    settle();
    chk("rs2_used_stall", 64'(bus.stall), 64'd1);
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_req(0, 1'b1, 5'd7, 32'h77);
    settle();
    chk("x7_grant_alu", 64'(bus.req_grant), 64'b001);
    push(5'd7, 32'h77);
    step();
    chk("x7_pending_clr", 64'(bus.pending), 64'd0);
    set_req(0, 1'b0, 5'd0, 32'h0);

    // Unexpected write to x9, then set/clear collision on x9
    set_req(1, 1'b1, 5'd9, 32'h99);
    settle();
    chk("unexp_grant", 64'(bus.req_grant), 64'b010);
    push(5'd9, 32'h99);
    step();
    chk("unexp_pending", 64'(bus.pending), 64'd0);
    set_req(1, 1'b1, 5'd9, 32'h999);
    issue(1'b1, 5'd9, 5'd0, 5'd0, 1'b0);
    settle();
    chk("coll_stall", 64'(bus.stall), 64'd0);
    chk("coll_grant", 64'(bus.req_grant), 64'b010);
    push(5'd9, 32'h999);
    step();
    chk("coll_pending", 64'(bus.pending), 64'h200);
    chk("coll_regwrite", 64'(bus.RegWrite), 64'd1);
    set_req(1, 1'b0, 5'd0, 32'h0);

    // Build pending = 0xF00, then reset with MUL waiting
    issue(1'b1, 5'd8, 5'd0, 5'd0, 1'b0);
    step();
    issue(1'b1, 5'd10, 5'd0, 5'd0, 1'b0);
    step();
    issue(1'b1, 5'd11, 5'd0, 5'd0, 1'b0);
    step();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("mid_pending", 64'(bus.pending), 64'hF00);
    set_req(2, 1'b1, 5'd12, 32'hC0);
    rst = 1'b1;
    settle();
    chk("mid_rst_grant", 64'(bus.req_grant), 64'd0);
    step();
    chk("mid_rst_pending", 64'(bus.pending), 64'd0);
    chk("mid_rst_regwrite", 64'(bus.RegWrite), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    set_req(0, 1'b1, 5'd13, 32'hD0);
    set_req(1, 1'b1, 5'd14, 32'hE0);
    settle();
    chk("mid_ptr_reset", 64'(bus.req_grant), 64'b001);
    push(5'd13, 32'hD0);
    step();
    chk("mid_regwrite", 64'(bus.RegWrite), 64'd1);
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b0, 5'd0, 32'h0);
    set_req(2, 1'b0, 5'd0, 32'h0);
    step();
    #3;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
